// File: rtl/maj_vote_n.sv
// maj_vote_n: pipelined N-input vote unit with mode select, threshold and persistence-filtered majority
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          sample votes/mode/thresh this cycle
//   votes[N-1:0]      vote vector, bit i = voter i asserts
//   mode[1:0]         00 threshold, 01 strict majority, 10 unanimous, 11 any
//   thresh[CW-1:0]    threshold for mode 00
//   out_valid         one-cycle pulse per accepted sample
//   count[CW-1:0]     popcount of the sample
//   raw               unfiltered decision
//   tie               2*count == N (always 0 for odd N)
//   maj               filtered decision, toggles after HOLD consecutive disagreeing samples
//   changed           one-cycle pulse when maj toggles
module maj_vote_n #(
    parameter int N = 4,
    parameter int HOLD = 3,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  votes,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] thresh,
    output logic          out_valid,
    output logic [CW-1:0] count,
    output logic          raw,
    output logic          tie,
    output logic          maj,
    output logic          changed
);
    localparam int SW = $clog2(HOLD + 1);
    logic          v1;
    logic [N-1:0]  vt1;
    logic [1:0]    md1;
    logic [CW-1:0] th1;
    logic [CW-1:0] cnt;
    logic          rw;
    logic          tw;
    logic [SW-1:0] streak;
    logic [SW:0]   inc;
    logic          flip;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            vt1 <= '0;
            md1 <= '0;
            th1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                vt1 <= votes;
                md1 <= mode;
                th1 <= thresh;
            end
        end
    end
    // doubled count is compared at CW+1 bits so 2*count never wraps
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + CW'(vt1[i]);
        rw = md1 == 2'b00 ? cnt >= th1 :
             md1 == 2'b01 ? {cnt, 1'b0} > (CW+1)'(N) :
             md1 == 2'b10 ? cnt == CW'(N) : cnt != '0;
        tw = (N % 2 == 0) && ({cnt, 1'b0} == (CW+1)'(N));
    end
    // the filter acts on the stage-1 sample so maj lines up with count/raw in the same cycle
    assign inc  = {1'b0, streak} + (SW+1)'(1);
    assign flip = v1 && (rw != maj) && (inc == (SW+1)'(HOLD));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            count     <= '0;
            raw       <= 1'b0;
            tie       <= 1'b0;
            maj       <= 1'b0;
            changed   <= 1'b0;
            streak    <= '0;
        end else begin
            out_valid <= v1;
            changed   <= flip;
            if (v1) begin
                count  <= cnt;
                raw    <= rw;
                tie    <= tw;
                maj    <= flip ? ~maj : maj;
                streak <= (rw == maj || flip) ? '0 : inc[SW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_maj_vote_n.sv
// tb_maj_vote_n: directed bench for maj_vote_n with three parameter sets sharing one stimulus
module tb_maj_vote_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] votes4 = '0;
    logic [4:0] votes5 = '0;
    logic [1:0] mode = '0;
    logic [2:0] thresh = '0;
    logic       a_ov, a_raw, a_tie, a_maj, a_chg;
    logic [2:0] a_cnt;
    logic       b_ov, b_raw, b_tie, b_maj, b_chg;
    logic [2:0] b_cnt;
    logic       c_ov, c_raw, c_tie, c_maj, c_chg;
    logic [2:0] c_cnt;
    int total = 0;
    int bad = 0;
    int nchg;
    logic [3:0] pv [6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0011};
    logic       pm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       pc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] two_of_four = 16'hFEE8;

    always #5 clk = ~clk;

    maj_vote_n #(.N(4), .HOLD(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes4), .mode(mode), .thresh(thresh),
        .out_valid(a_ov), .count(a_cnt), .raw(a_raw), .tie(a_tie), .maj(a_maj), .changed(a_chg)
    );
    maj_vote_n #(.N(4), .HOLD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes4), .mode(mode), .thresh(thresh),
        .out_valid(b_ov), .count(b_cnt), .raw(b_raw), .tie(b_tie), .maj(b_maj), .changed(b_chg)
    );
    maj_vote_n #(.N(5), .HOLD(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes5), .mode(mode), .thresh(thresh),
        .out_valid(c_ov), .count(c_cnt), .raw(c_raw), .tie(c_tie), .maj(c_maj), .changed(c_chg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // drives one sample, idles one cycle, and returns on the negedge where its result is visible
    task automatic one(input logic [4:0] v, input logic [1:0] m, input logic [2:0] t);
        in_valid = 1'b1;
        votes4 = v[3:0];
        votes5 = v;
        mode = m;
        thresh = t;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_ov", a_ov, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_maj", a_maj, 0);
        chk("rst_raw", a_raw, 0);
        do_reset();

        one(5'b00011, 2'b01, 3'd0);
        chk("sm_ov", a_ov, 1);
        chk("sm_cnt2", a_cnt, 2);
        chk("sm_raw2", a_raw, 0);
        chk("sm_tie2", a_tie, 1);
        chk("sm_maj2", a_maj, 0);
        one(5'b00111, 2'b01, 3'd0);
        chk("sm_cnt3", a_cnt, 3);
        chk("sm_raw3", a_raw, 1);
        chk("sm_tie3", a_tie, 0);
        chk("sm_maj3", a_maj, 1);
        chk("sm_chg3", a_chg, 1);
        chk("sm_ov3", a_ov, 1);
        @(negedge clk);
        chk("sm_chg_pulse", a_chg, 0);
        chk("sm_ov_pulse", a_ov, 0);
        chk("sm_hold_cnt", a_cnt, 3);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            if (i < 2 || i == 18) chk("sw_ov_idle", a_ov, 0);
            else begin
                chk("sw_ov", a_ov, 1);
                chk("sw_raw", a_raw, two_of_four[i-2]);
            end
            if (i < 16) begin
                in_valid = 1'b1;
                votes4 = 4'(i);
                mode = 2'b00;
                thresh = 3'd2;
            end else in_valid = 1'b0;
            @(negedge clk);
        end

        do_reset();
        nchg = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                chk("per_maj", b_maj, pm[i-2]);
                chk("per_chg", b_chg, pc[i-2]);
                nchg += int'(b_chg);
            end
            if (i < 6) begin
                in_valid = 1'b1;
                votes4 = pv[i];
                mode = 2'b11;
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        chk("per_nchg", nchg, 1);
        do_reset();
        nchg = 0;
        for (int i = 0; i < 6; i++) begin
            one({1'b0, pv[i]}, 2'b11, 3'd0);
            chk("pi_maj", b_maj, pm[i]);
            nchg += int'(b_chg);
        end
        chk("pi_nchg", nchg, 1);

        do_reset();
        one(5'b00000, 2'b00, 3'd0);
        chk("th0_raw", a_raw, 1);
        one(5'b01111, 2'b00, 3'd5);
        chk("th5_raw", a_raw, 0);
        one(5'b01110, 2'b10, 3'd0);
        chk("un_raw0", a_raw, 0);
        one(5'b01111, 2'b10, 3'd0);
        chk("un_raw1", a_raw, 1);
        chk("un_cnt", a_cnt, 4);
        one(5'b00111, 2'b01, 3'd0);
        chk("n5_raw", c_raw, 1);
        chk("n5_tie", c_tie, 0);
        chk("n5_cnt", c_cnt, 3);

        do_reset();
        in_valid = 1'b1;
        votes4 = 4'b1111;
        mode = 2'b11;
        repeat (4) @(negedge clk);
        chk("mr_pre_maj", a_maj, 1);
        chk("mr_pre_cnt", a_cnt, 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_ov", a_ov, 0);
        chk("mr_cnt", a_cnt, 0);
        chk("mr_raw", a_raw, 0);
        chk("mr_maj", a_maj, 0);
        chk("mr_bmaj", b_maj, 0);
        @(negedge clk);
        votes4 = 4'b0111;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_r0_ov", a_ov, 0);
        @(negedge clk);
        chk("mr_r1_ov", a_ov, 0);
        @(negedge clk);
        chk("mr_r2_ov", a_ov, 1);
        chk("mr_r2_cnt", a_cnt, 3);
        chk("mr_r2_bmaj", b_maj, 0);
        @(negedge clk);
        chk("mr_r3_bmaj", b_maj, 0);
        @(negedge clk);
        chk("mr_r4_bmaj", b_maj, 1);
        chk("mr_r4_bchg", b_chg, 1);
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maj_vote_n.md
# maj_vote_n

Parametrised, pipelined N-input vote unit with selectable decision mode, a runtime threshold and a persistence filter on the decision output. It takes a sampled vector of N one-bit votes from switch, sensor or redundant-channel inputs and produces a population count, a raw decision and a filtered majority output for LED or downstream control logic. It replaces fixed 4-input combinational majority gates wherever debounced, multi-mode voting is needed.

## Interface
- N, default 4: number of vote inputs; legal range 2..32.
- HOLD, default 3: consecutive qualifying samples required before `maj` changes; minimum 1.
- CW (localparam) = $clog2(N+1): width of the count and threshold fields.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  when high, `votes`, `mode` and `thresh` are sampled this cycle.
- votes  in  N  vote vector; bit i high means voter i asserts.
- mode  in  2  decision mode: 00 threshold, 01 strict majority, 10 unanimous, 11 any.
- thresh  in  CW  threshold for mode 00; sampled together with `votes`.
- out_valid  out  1  one-cycle pulse per accepted sample.
- count  out  CW  number of set bits in the sample.
- raw  out  1  unfiltered decision for the sample.
- tie  out  1  high when 2*count == N; constant 0 when N is odd.
- maj  out  1  filtered decision.
- changed  out  1  one-cycle pulse when `maj` toggles.

## Operation
- **Stage 1:** on an edge with in_valid=1, the block registers `votes`, `mode` and `thresh` and sets its internal valid bit. With in_valid=0, the valid bit clears and the data registers hold.
- **Stage 2:** count = popcount of the stage-1 votes, zero-extended to CW bits. No overflow is possible.
- **raw by mode:**
  - 00: count >= thresh. thresh=0 gives raw=1 always; thresh>N gives raw=0 always.
  - 01: 2*count > N, evaluated at CW+1 bits.
  - 10: count == N.
  - 11: count != 0.
- **Stage-2 registers:** count, raw, tie and out_valid register from the stage-1 contents. Registered outputs hold their values while out_valid=0.
- **Persistence filter (`streak`):**
  - `streak` is a saturating counter of width $clog2(HOLD+1). It updates only on valid stage-2 samples; invalid cycles leave it unchanged.
  - On a valid sample with raw == maj, streak is cleared to 0.
  - On a valid sample with raw != maj: if streak+1 == HOLD, maj toggles, changed=1 and streak is cleared; otherwise streak increments.
  - With HOLD=1, maj follows raw on every valid sample.
- **Mode switching:** mode and thresh changes take effect per sample. They do not clear streak.

## Timing
- Latency is 2 cycles. A sample accepted at edge k appears on count, raw, tie and out_valid after edge k+1, so it is visible in the cycle following that edge. maj and changed reflect the same sample in that same cycle.
- Throughput is one sample per cycle. Back-to-back in_valid is supported with no stalls and no backpressure.
- changed and out_valid are single-cycle pulses. changed is asserted only in a cycle where out_valid is also high.
- **Reset:** rst_n low immediately clears out_valid, count, raw, tie, maj, changed, streak and both pipeline valid bits to 0.
  - Samples in flight at reset are discarded; none emerge after release.
  - The first sample accepted on the first edge with rst_n high appears 2 cycles later.
- A simultaneous in_valid and rst_n release edge: the sample is accepted only if rst_n is high at that edge.

## Test plan
- **Strict majority:** N=4, HOLD=1, mode 01. votes 0011 -> count=2, raw=0, tie=1. votes 0111 -> count=3, raw=1, tie=0, maj=1 on the same out_valid, changed=1.
- **Threshold, legacy equivalence:** N=4, mode 00, thresh=2. Sweep all 16 vote patterns back-to-back -> raw matches "any two of four set" for every sample; out_valid stays high for 16 consecutive cycles starting 2 cycles after the first sample.
- **Persistence:** HOLD=3, mode 11, raw sequence 1,1,0,1,1,1 -> maj stays 0 through sample 5 and rises on sample 6. changed pulses exactly once. Interleaving idle cycles (in_valid=0) between samples gives an identical maj trajectory.
- **Mode boundaries:** N=4.
  - mode 00: thresh=0 with votes 0000 -> raw=1; thresh=5 with votes 1111 -> raw=0.
  - mode 10: votes 1110 -> raw=0; votes 1111 -> raw=1.
  - N=5, mode 01: votes 00111 -> raw=1, tie=0.
- **Reset mid-stream:** with in_valid held high, assert rst_n low mid-cycle -> all outputs go to 0 before the next clock edge. Release -> no out_valid for 2 cycles, then only post-reset samples appear. maj restarts from 0 and requires HOLD qualifying samples to change.
